// File: rtl/spybuffer_ctrl_if.sv
// Bundle between the spy buffer controller, the incoming stream, the spy buffer
// and the playback consumer.
interface spybuffer_ctrl_if #(
  parameter int DATA_WIDTH = 65
);
  // Valid/ready: a word moves only in a cycle where both valid and ready are 1;
  // once out_valid rises, out_data stays put until that cycle happens.
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  out_ready;
  logic                  buf_almost_full;
  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] buf_read_data;
  logic [DATA_WIDTH-1:0] buf_write_data;
  logic                  buf_write_enable;
  logic                  buf_read_enable;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;

  modport master (
    input  in_data, in_valid, out_ready, buf_almost_full, buf_empty, buf_read_data,
    output buf_write_data, buf_write_enable, buf_read_enable, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, out_ready, buf_almost_full, buf_empty, buf_read_data,
    input  buf_write_data, buf_write_enable, buf_read_enable, out_data, out_valid
  );
endinterface

// File: rtl/spybuffer_ctrl.sv
// Spy buffer controller: records a stream into an external FIFO on arm,
// stops on freeze or overflow, and drains the FIFO to a consumer on playback.
module spybuffer_ctrl #(
  parameter int DATA_WIDTH = 65,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  spybuffer_ctrl_if.master     bus,
  input  logic                 arm,
  input  logic                 freeze,
  input  logic                 playback,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 overflow,
  output logic                 done
);
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RECORD   = 2'd1,
    S_FROZEN   = 2'd2,
    S_PLAYBACK = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  accept_word, drop_word, clear_cnt, done_d, rd_en;
  logic                  wr_en_q, rd_pending_q, out_valid_q, overflow_q, done_q;
  logic [DATA_WIDTH-1:0] wr_data_q, out_data_q;
  logic [CNT_WIDTH-1:0]  word_count_q, event_count_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept_word = 1'b0;
    drop_word   = 1'b0;
    clear_cnt   = 1'b0;
    done_d      = 1'b0;
    rd_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_RECORD;
          clear_cnt = 1'b1;
        end
      end
      S_RECORD: begin
        if (freeze) begin
          state_d = S_FROZEN;
        end else if (bus.in_valid) begin
          if (bus.buf_almost_full) begin
            drop_word = 1'b1;
            state_d   = S_FROZEN;
          end else begin
            accept_word = 1'b1;
          end
        end
      end
      S_FROZEN: begin
        if (arm) begin
          state_d   = S_RECORD;
          clear_cnt = 1'b1;
        end else if (playback) begin
          if (bus.buf_empty) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PLAYBACK;
          end
        end
      end
      S_PLAYBACK: begin
        // out_ready=1 means any held word leaves this cycle, so one read at a time suffices.
        rd_en = !reset && !bus.buf_empty && bus.out_ready && !rd_pending_q;
        if (bus.buf_empty && !rd_pending_q && (!out_valid_q || bus.out_ready)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      rd_pending_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
      word_count_q  <= '0;
      event_count_q <= '0;
    end else begin
      wr_en_q      <= accept_word;
      rd_pending_q <= rd_en;
      done_q       <= done_d;
      if (accept_word) wr_data_q <= bus.in_data;
      if (clear_cnt) begin
        word_count_q  <= '0;
        event_count_q <= '0;
        overflow_q    <= 1'b0;
      end else begin
        if (accept_word && (word_count_q != '1))
          word_count_q <= word_count_q + CNT_WIDTH'(1);
        if (accept_word && bus.in_data[DATA_WIDTH-1] && (event_count_q != '1))
          event_count_q <= event_count_q + CNT_WIDTH'(1);
        if (drop_word) overflow_q <= 1'b1;
      end
      // Read data arrives the cycle after the strobe; capture it then.
      if (rd_pending_q) begin
        out_data_q  <= bus.buf_read_data;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.buf_write_enable = wr_en_q;
  assign bus.buf_write_data   = wr_data_q;
  assign bus.buf_read_enable  = rd_en;
  assign bus.out_data         = out_data_q;
  assign bus.out_valid        = out_valid_q;
  assign state                = state_q;
  assign word_count           = word_count_q;
  assign event_count          = event_count_q;
  assign overflow             = overflow_q;
  assign done                 = done_q;
endmodule

// File: tb/tb_spybuffer_ctrl.sv
// Bench for spybuffer_ctrl: behavioural spy FIFO, write/playback scoreboards,
// directed record / freeze / overflow / playback / reset scenarios.
module tb_spybuffer_ctrl;
  localparam int W  = 65;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0, freeze = 1'b0, playback = 1'b0;
  logic [1:0]    state;
  logic [CW-1:0] word_count, event_count;
  logic          overflow, done;

  spybuffer_ctrl_if #(.DATA_WIDTH(W)) bus ();

  spybuffer_ctrl #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .arm         (arm),
    .freeze      (freeze),
    .playback    (playback),
    .state       (state),
    .word_count  (word_count),
    .event_count (event_count),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_cnt = 0;
  int done_cnt = 0;

  logic [W-1:0] wr_exp_q[$];
  int           wr_cyc_q[$];
  logic [W-1:0] out_exp_q[$];
  logic [W-1:0] fifo[$];

  logic         we_s = 1'b0, re_s = 1'b0, held = 1'b0;
  logic [W-1:0] wd_s = '0, held_data = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Spy FIFO model: acts at the edge on what the DUT showed during the previous cycle.
  initial begin
    bus.buf_empty     = 1'b1;
    bus.buf_read_data = '0;
  end

  always @(posedge clock) begin
    cyc++;
    if (we_s) fifo.push_back(wd_s);
    if (re_s && fifo.size() != 0) bus.buf_read_data <= fifo.pop_front();
    bus.buf_empty <= (fifo.size() == 0);
  end

  always @(negedge clock) begin
    we_s = bus.buf_write_enable;
    wd_s = bus.buf_write_data;
    re_s = bus.buf_read_enable;
    if (!reset) begin
      if (we_s || re_s) check("rw_excl", W'(we_s && re_s), '0);
      if (we_s) begin
        if (wr_exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          check("wr_data", wd_s, wr_exp_q.pop_front());
          check("wr_latency", W'(cyc), W'(wr_cyc_q.pop_front()));
        end
      end
      if (held) begin
        check("hold_valid", W'(bus.out_valid), 1);
        check("hold_data", bus.out_data, held_data);
      end
      if (bus.out_valid && !bus.out_ready) check("hold_noread", W'(re_s), 0);
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (out_exp_q.size() == 0) check("out_unexpected", 1, 0);
        else check("out_data", bus.out_data, out_exp_q.pop_front());
      end
      if (done) done_cnt++;
      held      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
    end else begin
      held = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    wr_exp_q.push_back(w);
    wr_cyc_q.push_back(cyc + 1);
    out_exp_q.push_back(w);
  endtask

  task automatic record_words(input int n, input logic [4:0] msb_mask);
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {msb_mask[i], 32'($urandom), 32'($urandom)};
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      push_word(w);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check("done_timeout", W'(done), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, W'(state), 0);
    check({tag, "_we"}, W'(bus.buf_write_enable), 0);
    check({tag, "_re"}, W'(bus.buf_read_enable), 0);
    check({tag, "_ov"}, W'(bus.out_valid), 0);
    check({tag, "_done"}, W'(done), 0);
    check({tag, "_overflow"}, W'(overflow), 0);
    check({tag, "_wc"}, W'(word_count), 0);
    check({tag, "_ec"}, W'(event_count), 0);
    check({tag, "_wd"}, bus.buf_write_data, 0);
    check({tag, "_od"}, bus.out_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0, n;
    logic [3:0] pat;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.buf_almost_full = 1'b0;
    pat = 4'b1001;

    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Record five words, boundary flags on the 3rd and 5th.
    arm = 1'b1; tick(); arm = 1'b0;
    check("t1_record", W'(state), 1);
    record_words(5, 5'b10100);
    freeze = 1'b1; tick(); freeze = 1'b0; tick();
    check("t1_wc", W'(word_count), 5);
    check("t1_ec", W'(event_count), 2);
    check("t1_frozen", W'(state), 2);
    check("t1_wr_left", W'(wr_exp_q.size()), 0);

    // Drain with out_ready stepping 1,0,0,1.
    d0 = done_cnt;
    playback = 1'b1; bus.out_ready = 1'b1; tick(); playback = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      bus.out_ready = pat[n % 4];
      tick();
      n++;
    end
    check("t2_done_timeout", W'(done), 1);
    bus.out_ready = 1'b0;
    tick(); tick();
    check("t2_done_once", W'(done_cnt - d0), 1);
    check("t2_idle", W'(state), 0);
    check("t2_out_left", W'(out_exp_q.size()), 0);

    // Three words, drain at full rate.
    arm = 1'b1; tick(); arm = 1'b0;
    record_words(3, 5'b00010);
    freeze = 1'b1; tick(); freeze = 1'b0; tick();
    d0 = done_cnt; o0 = out_cnt;
    playback = 1'b1; bus.out_ready = 1'b1; tick(); playback = 1'b0;
    check("t3_playback", W'(state), 3);
    wait_done(100);
    tick(); tick();
    check("t3_out_cnt", W'(out_cnt - o0), 3);
    check("t3_done_once", W'(done_cnt - d0), 1);
    check("t3_idle", W'(state), 0);
    check("t3_out_left", W'(out_exp_q.size()), 0);

    // Freeze beats a same-cycle input word.
    arm = 1'b1; tick(); arm = 1'b0;
    record_words(1, 5'b00001);
    bus.in_valid = 1'b1; bus.in_data = {1'b1, 32'($urandom), 32'($urandom)};
    freeze = 1'b1; tick();
    freeze = 1'b0; bus.in_valid = 1'b0; tick();
    check("t4_wc", W'(word_count), 1);
    check("t4_ec", W'(event_count), 1);
    check("t4_frozen", W'(state), 2);
    check("t4_wr_left", W'(wr_exp_q.size()), 0);

    // Arm beats a same-cycle playback and clears the counters.
    arm = 1'b1; playback = 1'b1; tick(); arm = 1'b0; playback = 1'b0;
    check("t5_record", W'(state), 1);
    check("t5_wc", W'(word_count), 0);
    check("t5_ec", W'(event_count), 0);
    freeze = 1'b1; tick(); freeze = 1'b0;
    check("t5_frozen", W'(state), 2);

    // Input while almost full: dropped, overflow, frozen.
    arm = 1'b1; tick(); arm = 1'b0;
    check("t6_record", W'(state), 1);
    bus.buf_almost_full = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = {1'b0, 32'($urandom), 32'($urandom)};
    tick();
    bus.in_valid = 1'b0;
    check("t6_frozen", W'(state), 2);
    check("t6_overflow", W'(overflow), 1);
    check("t6_no_write", W'(bus.buf_write_enable), 0);
    check("t6_wc", W'(word_count), 0);
    bus.buf_almost_full = 1'b0;
    tick();
    check("t6_sticky", W'(overflow), 1);

    // Reset one cycle after a playback read discards the word.
    bus.out_ready = 1'b1;
    playback = 1'b1; tick(); playback = 1'b0;
    check("t7_playback", W'(state), 3);
    check("t7_read", W'(bus.buf_read_enable), 1);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_all_zero("t7");
    out_exp_q.delete();
    o0 = out_cnt;
    repeat (4) tick();
    check("t7_no_out", W'(out_cnt - o0), 0);

    // Playback on an empty buffer goes straight to IDLE with done.
    arm = 1'b1; tick(); arm = 1'b0;
    freeze = 1'b1; tick(); freeze = 1'b0;
    check("t8_frozen", W'(state), 2);
    playback = 1'b1; tick(); playback = 1'b0;
    check("t8_idle", W'(state), 0);
    check("t8_done", W'(done), 1);
    tick();
    check("t8_done_pulse", W'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
